mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single data-memory port (flop or SRAM backend, VALID/READY handshake) between two
//  requesters: M0 = core LSU, M1 = debug/DMA loader. Latches the winning request, drives it to
//  the memory until i_READY, then routes the completion back to the granted requester.
//  Times out hung transactions.
// PARAMETERS
//  ARB_MODE  1    0: fixed priority (M0 wins), 1: round-robin between M0/M1
//  TIMEOUT   255  max BUSY cycles waiting for i_READY before abort; 0 disables timeout
// PORTS
//  i_clk        in   1   clock
//  i_rst_n      in   1   synchronous, active-low reset
//  i_Mx_ADDR    in   18  requester x (x=0,1) byte address
//  i_Mx_WDATA   in   32  write data
//  i_Mx_BMASK   in   4   byte-enable mask
//  i_Mx_WREN    in   1   1: write, 0: read
//  i_Mx_VALID   in   1   request valid; held with fields stable until o_Mx_READY
//  o_Mx_READY   out  1   1-cycle completion pulse to requester x
//  o_Mx_RDATA   out  32  read data, valid only while o_Mx_READY=1, else 0
//  o_Mx_ERR     out  1   asserted with o_Mx_READY when transaction timed out
//  o_ADDR       out  18  to memory: latched address
//  o_WDATA      out  32  to memory: latched write data
//  o_BMASK      out  4   to memory: latched byte mask
//  o_WREN       out  1   to memory: latched write enable
//  o_VALID      out  1   to memory: request valid
//  i_READY      in   1   from memory: transaction done
//  i_RDATA      in   32  from memory: read data, valid with i_READY
//  o_GNT        out  2   one-hot current grant (00 when IDLE)
//  o_BUSY       out  1   1 while in BUSY state
// BEHAVIOUR
//  - Reset (sync, i_rst_n=0 at edge): state=IDLE, rr pointer=M0, timeout counter=0; all outputs 0.
//    Reset mid-transaction aborts with no READY/ERR to either requester; o_VALID 0 next cycle.
//  - FSM IDLE: if any i_Mx_VALID, pick winner, register its ADDR/WDATA/BMASK/WREN into o_*,
//    set o_GNT, clear counter -> BUSY. No valid: stay, o_VALID=0.
//  - FSM BUSY: o_VALID=1, o_* held constant. On i_READY: o_Mx_READY=1 (granted x only),
//    o_Mx_RDATA=i_RDATA (combinational pass), -> IDLE, o_GNT=00 next cycle.
//  - Timeout: counter increments each BUSY cycle without i_READY; when it equals TIMEOUT-1 and
//    i_READY=0: pulse o_Mx_READY=1 and o_Mx_ERR=1, o_Mx_RDATA=0, -> IDLE (o_VALID drops).
//    i_READY on that same cycle wins: normal completion, no ERR.
//  - Latency: request accepted in IDLE cycle N, o_VALID from N+1; with flop memory (READY=1
//    same cycle) completion in N+1. Mandatory 1-cycle IDLE bubble between transactions, so
//    o_VALID deasserts for >=1 cycle (memory sees a fresh request edge).
//  - Arbitration (both valid in IDLE): ARB_MODE=0 -> M0. ARB_MODE=1 -> port named by rr
//    pointer; pointer moves to the other port on every completion (normal or timeout) of the
//    granted one. Single valid -> that port regardless of pointer.
//  - Non-granted requester: o_Mx_READY=0, o_Mx_ERR=0, o_Mx_RDATA=0 at all times.
//  - A requester dropping VALID while granted is illegal; arbiter still completes and pulses READY.
//  - o_GNT one-hot or zero; o_BUSY == |o_GNT.
// TESTING
//  1 Reset: hold i_rst_n=0 with both VALIDs=1 -> all outputs 0; release -> GNT=01 next cycle (RR ptr=M0).
//  2 M0 read ADDR=0x00010, memory READY 2 cycles after o_VALID, RDATA=0xDEADBEEF ->
//    o_M0_READY pulse with o_M0_RDATA=0xDEADBEEF, o_M1_READY=0, ERR=0.
//  3 ARB_MODE=1, both valid continuously, flop memory -> grants alternate 01,10,01,10;
//    each completion 2 cycles apart; o_VALID low 1 cycle between.
//  4 ARB_MODE=0, both valid -> M0 granted every transaction, M1 starved while M0 valid.
//  5 TIMEOUT=4, i_READY stuck 0 on M1 write -> after 4 BUSY cycles o_M1_READY=o_M1_ERR=1,
//    RDATA=0, IDLE next; repeat with i_READY=1 on cycle 4 -> ERR=0.
//  6 Assert i_rst_n=0 during BUSY -> next cycle o_VALID=0, GNT=00, no READY/ERR pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// M0 is the core LSU and M1 is the debug/DMA loader. The winning request is
// latched and presented to memory until i_READY arrives. The completion is then
// routed back to the granted requester only. A transaction that hangs in BUSY is
// aborted after TIMEOUT cycles with an error pulse.
module mem_arbiter #(
  parameter int ARB_MODE = 1,   // 0: fixed priority (M0 wins), 1: round-robin
  parameter int TIMEOUT  = 255  // BUSY cycles before abort; 0 disables
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [17:0] i_M0_ADDR,
  input  logic [31:0] i_M0_WDATA,
  input  logic [3:0]  i_M0_BMASK,
  input  logic        i_M0_WREN,
  input  logic        i_M0_VALID,
  output logic        o_M0_READY,
  output logic [31:0] o_M0_RDATA,
  output logic        o_M0_ERR,
  input  logic [17:0] i_M1_ADDR,
  input  logic [31:0] i_M1_WDATA,
  input  logic [3:0]  i_M1_BMASK,
  input  logic        i_M1_WREN,
  input  logic        i_M1_VALID,
  output logic        o_M1_READY,
  output logic [31:0] o_M1_RDATA,
  output logic        o_M1_ERR,
  output logic [17:0] o_ADDR,
  output logic [31:0] o_WDATA,
  output logic [3:0]  o_BMASK,
  output logic        o_WREN,
  output logic        o_VALID,
  input  logic        i_READY,
  input  logic [31:0] i_RDATA,
  output logic [1:0]  o_GNT,
  output logic        o_BUSY
);

  // The counter only has to reach TIMEOUT-1, so it is sized for that value.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              rr_q, rr_d;       // 0: M0 next on contention, 1: M1
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [17:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bmask_q, bmask_d;
  logic              wren_q, wren_d;

  logic              busy;
  logic              win;              // winning port index in IDLE
  logic              to_hit;           // abort this cycle
  logic              done;             // transaction ends this cycle

  assign busy = (state_q == S_BUSY);

  // Next-state logic: arbitration and latching in IDLE, completion and timeout in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    wren_d  = wren_q;
    win     = 1'b0;
    to_hit  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_M0_VALID || i_M1_VALID) begin
          // The pointer only matters on contention; a lone requester always wins.
          if (i_M0_VALID && i_M1_VALID) begin
            win = (ARB_MODE != 0) ? rr_q : 1'b0;
          end else begin
            win = i_M1_VALID;
          end
          addr_d  = win ? i_M1_ADDR  : i_M0_ADDR;
          wdata_d = win ? i_M1_WDATA : i_M0_WDATA;
          bmask_d = win ? i_M1_BMASK : i_M0_BMASK;
          wren_d  = win ? i_M1_WREN  : i_M0_WREN;
          gnt_d   = win ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // A READY arriving in the last allowed cycle still counts as normal completion.
        to_hit = TO_EN && !i_READY && (cnt_q == CNT_LAST);
        done   = i_READY || to_hit;
        if (done) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          // Hand priority to the port that was not just served.
          rr_d    = gnt_q[0];
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers. Everything clears so that all outputs are 0 in reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      wren_q  <= wren_d;
    end
  end

  // Requester responses. These are gated by reset so that an aborted transaction never pulses.
  always_comb begin
    o_M0_READY = i_rst_n && done && gnt_q[0];
    o_M1_READY = i_rst_n && done && gnt_q[1];
    o_M0_ERR   = i_rst_n && to_hit && gnt_q[0];
    o_M1_ERR   = i_rst_n && to_hit && gnt_q[1];
    o_M0_RDATA = (i_rst_n && busy && i_READY && gnt_q[0]) ? i_RDATA : 32'd0;
    o_M1_RDATA = (i_rst_n && busy && i_READY && gnt_q[1]) ? i_RDATA : 32'd0;
  end

  assign o_ADDR  = addr_q;
  assign o_WDATA = wdata_q;
  assign o_BMASK = bmask_q;
  assign o_WREN  = wren_q;
  assign o_VALID = busy;
  assign o_BUSY  = busy;
  assign o_GNT   = gnt_q;

endmodule
